// File: rtl/mem_pkg.sv
// Shared types and constants for the main-memory responder.
// Also holds the helper that sizes the byte offset within a line.
package mem_pkg;

    localparam int LINE_WORDS = 4;
    localparam int WORD_BYTES = 4;

    localparam logic REQ_ICACHE = 1'b0;
    localparam logic REQ_DCACHE = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST,
        WACK
    } mem_state_t;

    function automatic int line_off_w(input int line_words);
        return $clog2(line_words * WORD_BYTES);
    endfunction

endpackage

// File: rtl/mem_sram_1rw.sv
// Single-port backing store: synchronous write, combinational read.
// It has no reset, so the contents survive a responder reset.
module mem_sram_1rw #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/main_mem_responder.sv
// Main-memory responder: accepts one read-line or write-word request at a time,
// waits a fixed latency, then returns a line burst or a single write ack.
module main_mem_responder #(
    parameter int ADDR_W      = 32,
    parameter int LINE_WORDS  = mem_pkg::LINE_WORDS,
    parameter int LATENCY     = 8,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          main_mem_valid,
    input  logic [ADDR_W-1:0]             main_mem_addr,
    input  logic                          main_mem_we,
    input  logic [31:0]                   main_mem_wdata,
    input  logic                          main_mem_id,
    output logic                          main_mem_ready,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [31:0]                   resp_data,
    output logic [$clog2(LINE_WORDS)-1:0] resp_beat,
    output logic                          resp_last,
    output logic                          resp_is_write,
    output logic                          resp_id
);
    import mem_pkg::*;

    localparam int BEAT_W = line_off_w(LINE_WORDS) - $clog2(WORD_BYTES);
    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    mem_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              id_q, id_d;
    logic              ready_q, ready_d;
    logic              valid_q, valid_d;
    logic [31:0]       data_q, data_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              last_q, last_d;
    logic              is_write_q, is_write_d;
    logic              rid_q, rid_d;

    logic              mem_we;
    logic [IDX_W-1:0]  mem_addr;
    logic [31:0]       mem_rdata;
    logic [BEAT_W-1:0] rd_beat;
    logic              addr_unused;

    // Address bits beyond the array and the byte offset are deliberately dropped.
    assign addr_unused = ^{main_mem_addr[ADDR_W-1:IDX_W+2], main_mem_addr[1:0]};

    // Read port always looks at the word the next registered beat will carry.
    assign rd_beat  = (state_q == BURST) ? beat_q + BEAT_W'(1) : '0;
    assign mem_addr = we_q ? idx_q : {idx_q[IDX_W-1:BEAT_W], rd_beat};

    mem_sram_1rw #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_sram (
        .clk  (clk),
        .we   (mem_we),
        .addr (mem_addr),
        .wdata(wdata_q),
        .rdata(mem_rdata)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        id_d       = id_q;
        ready_d    = ready_q;
        valid_d    = valid_q;
        data_d     = data_q;
        beat_d     = beat_q;
        last_d     = last_q;
        is_write_d = is_write_q;
        rid_d      = rid_q;
        mem_we     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (main_mem_valid && ready_q) begin
                    idx_d   = main_mem_addr[IDX_W+1:2];
                    we_d    = main_mem_we;
                    wdata_d = main_mem_wdata;
                    id_d    = main_mem_id;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    ready_d = 1'b0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    valid_d = 1'b1;
                    rid_d   = id_q;
                    beat_d  = '0;
                    if (we_q) begin
                        mem_we     = 1'b1;
                        data_d     = '0;
                        last_d     = 1'b1;
                        is_write_d = 1'b1;
                        state_d    = WACK;
                    end else begin
                        data_d     = mem_rdata;
                        last_d     = 1'b0;
                        is_write_d = 1'b0;
                        state_d    = BURST;
                    end
                end
            end
            BURST: begin
                if (valid_q && resp_ready) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        data_d  = '0;
                        beat_d  = '0;
                        ready_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        beat_d = rd_beat;
                        data_d = mem_rdata;
                        last_d = (rd_beat == BEAT_W'(LINE_WORDS - 1));
                    end
                end
            end
            WACK: begin
                if (valid_q && resp_ready) begin
                    valid_d    = 1'b0;
                    last_d     = 1'b0;
                    is_write_d = 1'b0;
                    ready_d    = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            id_q       <= REQ_ICACHE;
            ready_q    <= 1'b1;
            valid_q    <= 1'b0;
            data_q     <= '0;
            beat_q     <= '0;
            last_q     <= 1'b0;
            is_write_q <= 1'b0;
            rid_q      <= REQ_ICACHE;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            id_q       <= id_d;
            ready_q    <= ready_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            beat_q     <= beat_d;
            last_q     <= last_d;
            is_write_q <= is_write_d;
            rid_q      <= rid_d;
        end
    end

    assign main_mem_ready = ready_q;
    assign resp_valid     = valid_q;
    assign resp_data      = data_q;
    assign resp_beat      = beat_q;
    assign resp_last      = last_q;
    assign resp_is_write  = is_write_q;
    assign resp_id        = rid_q;

endmodule

// File: tb/tb_main_mem_responder.sv
// Self-checking bench for main_mem_responder: directed scenarios plus random
// traffic, compared against a word-array model of the backing store.
module tb_main_mem_responder;
    import mem_pkg::*;

    localparam int LW    = 4;
    localparam int LAT   = 8;
    localparam int DEPTH = 1024;

    logic        clk;
    logic        rst;
    logic        main_mem_valid;
    logic [31:0] main_mem_addr;
    logic        main_mem_we;
    logic [31:0] main_mem_wdata;
    logic        main_mem_id;
    logic        main_mem_ready;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [1:0]  resp_beat;
    logic        resp_last;
    logic        resp_is_write;
    logic        resp_id;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int end_cyc = 0;

    // Reference store: only words the bench has written are known.
    logic [31:0] model_mem [DEPTH];
    bit          known [DEPTH];

    main_mem_responder #(
        .ADDR_W     (32),
        .LINE_WORDS (LW),
        .LATENCY    (LAT),
        .DEPTH_WORDS(DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .main_mem_valid(main_mem_valid),
        .main_mem_addr (main_mem_addr),
        .main_mem_we   (main_mem_we),
        .main_mem_wdata(main_mem_wdata),
        .main_mem_id   (main_mem_id),
        .main_mem_ready(main_mem_ready),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_data     (resp_data),
        .resp_beat     (resp_beat),
        .resp_last     (resp_last),
        .resp_is_write (resp_is_write),
        .resp_id       (resp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int word_of(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic check_reset(input string pfx);
        checkOutput({pfx, "_ready"},    main_mem_ready, 1);
        checkOutput({pfx, "_valid"},    resp_valid,     0);
        checkOutput({pfx, "_data"},     resp_data,      0);
        checkOutput({pfx, "_beat"},     resp_beat,      0);
        checkOutput({pfx, "_last"},     resp_last,      0);
        checkOutput({pfx, "_is_write"}, resp_is_write,  0);
        checkOutput({pfx, "_id"},       resp_id,        0);
    endtask

    // Called at a negedge; returns at the negedge after the request is accepted.
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] data, input logic id);
        int g = 0;
        main_mem_valid = 1'b1;
        main_mem_we    = we;
        main_mem_addr  = addr;
        main_mem_wdata = data;
        main_mem_id    = id;
        while (main_mem_ready !== 1'b1 && g < 200) begin
            @(negedge clk);
            g++;
        end
        checkOutput("accept_timeout", main_mem_ready, 1);
        @(negedge clk);
        main_mem_valid = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic wait_resp();
        int g = 0;
        while (resp_valid !== 1'b1 && g < LAT + 16) begin
            checkOutput("busy_ready", main_mem_ready, 0);
            @(negedge clk);
            g++;
        end
        checkOutput("resp_timeout", resp_valid, 1);
        checkOutput("latency", cyc - acc_cyc, LAT);
    endtask

    task automatic collect_write(input logic id, input bit stall);
        wait_resp();
        if (stall) begin
            resp_ready = 1'b0;
            @(negedge clk);
            checkOutput("wack_hold_valid", resp_valid, 1);
        end
        resp_ready = 1'b1;
        checkOutput("wack_is_write", resp_is_write, 1);
        checkOutput("wack_last",     resp_last,     1);
        checkOutput("wack_beat",     resp_beat,     0);
        checkOutput("wack_data",     resp_data,     0);
        checkOutput("wack_id",       resp_id,       id);
        @(negedge clk);
        resp_ready = 1'b0;
        checkOutput("wack_done_valid", resp_valid,     0);
        checkOutput("wack_done_ready", main_mem_ready, 1);
    endtask

    // mode 0: ready always high, 1: pattern 1,0,0 repeating, 2: random.
    task automatic collect_read(input logic [31:0] addr, input logic id, input int mode, input int stop);
        int          beats = 0;
        int          base;
        bit          rdy;
        bit          stalled = 0;
        logic [31:0] pdata = '0;
        logic [1:0]  pbeat = '0;
        logic        plast = 1'b0;
        base = word_of(addr) & ~(LW - 1);
        wait_resp();
        for (int g = 0; g < 400 && beats < stop; g++) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (g % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            resp_ready = rdy;
            checkOutput("rd_valid",      resp_valid,     1);
            checkOutput("rd_busy_ready", main_mem_ready, 0);
            if (stalled) begin
                checkOutput("rd_hold_data", resp_data, pdata);
                checkOutput("rd_hold_beat", resp_beat, pbeat);
                checkOutput("rd_hold_last", resp_last, plast);
            end
            checkOutput("rd_beat", resp_beat, beats);
            if (known[base + beats]) checkOutput("rd_data", resp_data, model_mem[base + beats]);
            checkOutput("rd_last",     resp_last,     (beats == LW - 1));
            checkOutput("rd_id",       resp_id,       id);
            checkOutput("rd_is_write", resp_is_write, 0);
            pdata   = resp_data;
            pbeat   = resp_beat;
            plast   = resp_last;
            stalled = !rdy;
            if (rdy) beats++;
            @(negedge clk);
        end
        resp_ready = 1'b0;
        checkOutput("rd_beat_count", beats, stop);
        if (stop == LW) begin
            checkOutput("rd_done_valid", resp_valid,     0);
            checkOutput("rd_done_ready", main_mem_ready, 1);
            if (mode == 0) checkOutput("rd_occupancy", cyc - acc_cyc, LAT + LW);
        end
        end_cyc = cyc;
    endtask

    task automatic write_word(input logic [31:0] addr, input logic [31:0] data, input logic id, input bit stall);
        applyStimulus(1'b1, addr, data, id);
        collect_write(id, stall);
        model_mem[word_of(addr)] = data;
        known[word_of(addr)]     = 1'b1;
    endtask

    task automatic read_line(input logic [31:0] addr, input logic id, input int mode, input int stop);
        applyStimulus(1'b0, addr, $urandom, id);
        collect_read(addr, id, mode, stop);
    endtask

    initial begin
        logic [31:0] a;
        rst            = 1'b1;
        main_mem_valid = 1'b0;
        main_mem_addr  = '0;
        main_mem_we    = 1'b0;
        main_mem_wdata = '0;
        main_mem_id    = 1'b0;
        resp_ready     = 1'b0;

        $display("[TB] reset");
        repeat (3) @(negedge clk);
        check_reset("rst_hold");
        rst = 1'b0;
        @(negedge clk);
        check_reset("rst_release");

        $display("[TB] write then read");
        write_word(32'h0000_0104, 32'hDEADBEEF, REQ_DCACHE, 1'b0);
        read_line(32'h0000_010C, REQ_ICACHE, 0, LW);

        $display("[TB] backpressure");
        for (int i = 0; i < LW; i++) write_word(32'h0000_0180 + 32'(4 * i), $urandom, REQ_DCACHE, 1'b0);
        read_line(32'h0000_0184, REQ_DCACHE, 1, LW);

        $display("[TB] busy ignore");
        applyStimulus(1'b0, 32'h0000_0100, 32'h0, REQ_ICACHE);
        main_mem_valid = 1'b1;
        main_mem_we    = 1'b1;
        main_mem_addr  = 32'h0000_0200;
        main_mem_wdata = 32'hCAFEF00D;
        main_mem_id    = REQ_DCACHE;
        collect_read(32'h0000_0100, REQ_ICACHE, 0, LW);
        write_word(32'h0000_0200, 32'hCAFEF00D, REQ_DCACHE, 1'b0);
        checkOutput("busy_accept_cycle", acc_cyc, end_cyc + 1);
        read_line(32'h0000_0200, REQ_DCACHE, 2, LW);

        $display("[TB] address wrap");
        write_word(32'(4 * DEPTH + 8), 32'h12345678, REQ_DCACHE, 1'b1);
        read_line(32'h0000_0000, REQ_ICACHE, 0, LW);

        $display("[TB] reset during write wait");
        applyStimulus(1'b1, 32'h0000_0104, 32'h0BADF00D, REQ_DCACHE);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset("rst_wait");
        @(negedge clk);
        rst = 1'b0;
        read_line(32'h0000_0100, REQ_ICACHE, 0, LW);

        $display("[TB] reset mid-burst");
        for (int i = 0; i < LW; i++) write_word(32'h0000_0300 + 32'(4 * i), $urandom, REQ_DCACHE, 1'b0);
        read_line(32'h0000_0300, REQ_ICACHE, 0, 2);
        #2 rst = 1'b1;
        #1 check_reset("rst_burst");
        @(negedge clk);
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            checkOutput("rst_burst_quiet", resp_valid, 0);
        end
        read_line(32'h0000_0300, REQ_DCACHE, 0, LW);

        $display("[TB] random traffic");
        for (int i = 0; i < 40; i++) begin
            a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                write_word(a, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else
                read_line(a, 1'($urandom_range(0, 1)), 2, LW);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
